// File: rtl/tone_oscillator_if.sv
// Sample stream from tone_oscillator to the codec serializer.
// Master drives sample/sample_valid; slave returns sample_ready.
interface tone_oscillator_if;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/tone_oscillator.sv
// Phase-accumulator tone generator: Hz in, signed 16-bit samples out; define TONE_OSC_TRIANGLE_EN for triangle on wave_sel=2.
// Latency: sample/sample_valid update on the edge that samples sample_tick (1 cycle).
// Backpressure: a tick while a sample is unconsumed is dropped and sets sticky overrun.
module tone_oscillator #(
    parameter int PHASE_BITS     = 24,
    parameter int PHASE_INC_MULT = 350,
    parameter int SQUARE_AMP     = 8192
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [13:0]         frequency,
    input  logic [1:0]          wave_sel,
    input  logic [2:0]          volume,
    input  logic                sample_tick,
    output logic                overrun,
    tone_oscillator_if.master   audio
);
    typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

    localparam logic signed [15:0] SQ_POS = 16'(SQUARE_AMP);
    localparam logic signed [15:0] SQ_NEG = 16'(-SQUARE_AMP);

    state_t                  state, state_nxt;
    logic [PHASE_BITS-1:0]   phase, phase_nxt;
    logic [13:0]             freq_active, freq_nxt;
    logic signed [15:0]      sample_q, sample_nxt;
    logic                    valid_q, valid_nxt;
    logic                    overrun_nxt;

    logic [PHASE_BITS-1:0]   inc;
    logic [PHASE_BITS:0]     sum;
    logic                    carry;
    logic [15:0]             p;
    logic signed [15:0]      square, saw, wave, shaped;
    logic                    accept;

    assign inc   = PHASE_BITS'(32'(freq_active) * PHASE_INC_MULT);
    assign sum   = {1'b0, phase} + {1'b0, inc};
    assign carry = sum[PHASE_BITS];
    assign p     = phase[PHASE_BITS-1 -: 16];

    assign square = p[15] ? SQ_NEG : SQ_POS;
    assign saw    = p ^ 16'h8000;

`ifdef TONE_OSC_TRIANGLE_EN
    logic [15:0]        tri_ramp;
    logic signed [15:0] triangle;
    assign tri_ramp = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
    assign triangle = tri_ramp ^ 16'h8000;
`endif

    always_comb begin
        wave = square;
        case (wave_sel)
            2'd1:    wave = saw;
`ifdef TONE_OSC_TRIANGLE_EN
            2'd2:    wave = triangle;
`endif
            default: wave = square;
        endcase
    end

    assign shaped = wave >>> volume;

    // A tick is taken when the output slot is empty or being drained this cycle.
    assign accept = sample_tick && (!valid_q || audio.sample_ready);

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        freq_nxt    = freq_active;
        sample_nxt  = sample_q;
        valid_nxt   = valid_q && !audio.sample_ready;
        overrun_nxt = overrun || (sample_tick && valid_q && !audio.sample_ready);
        if (accept) begin
            valid_nxt = 1'b1;
            case (state)
                IDLE: begin
                    sample_nxt = '0;
                    if (frequency != 14'd0) begin
                        freq_nxt  = frequency;
                        phase_nxt = '0;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    sample_nxt = shaped;
                    phase_nxt  = sum[PHASE_BITS-1:0];
                    if (frequency != freq_active)
                        state_nxt = PENDING;
                end
                PENDING: begin
                    sample_nxt = shaped;
                    // Retune only at the period boundary; the leftover phase is dropped.
                    if (carry) begin
                        freq_nxt  = frequency;
                        phase_nxt = '0;
                        state_nxt = (frequency == 14'd0) ? IDLE : RUN;
                    end else begin
                        phase_nxt = sum[PHASE_BITS-1:0];
                        if (frequency == freq_active)
                            state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            phase       <= '0;
            freq_active <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            freq_active <= freq_nxt;
            sample_q    <= sample_nxt;
            valid_q     <= valid_nxt;
            overrun     <= overrun_nxt;
        end
    end

    assign audio.sample       = sample_q;
    assign audio.sample_valid = valid_q;
endmodule

// File: tb/tb_tone_oscillator.sv
// Directed-vector bench for tone_oscillator with hand-computed sample values.
module tb_tone_oscillator;
    logic        clock = 1'b0;
    logic        resetn;
    logic [13:0] frequency;
    logic [1:0]  wave_sel;
    logic [2:0]  volume;
    logic        sample_tick;
    logic        overrun;
    int          n_vec = 0;
    int          n_bad = 0;

    tone_oscillator_if audio();

    tone_oscillator dut (
        .clock       (clock),
        .resetn      (resetn),
        .frequency   (frequency),
        .wave_sel    (wave_sel),
        .volume      (volume),
        .sample_tick (sample_tick),
        .overrun     (overrun),
        .audio       (audio)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(posedge clock);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        sample_tick = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    function automatic int smp();
        return int'(audio.sample);
    endfunction

    initial begin
        resetn             = 1'b0;
        frequency          = '0;
        wave_sel           = 2'd0;
        volume             = 3'd0;
        sample_tick        = 1'b0;
        audio.sample_ready = 1'b1;

        // Reset state and silence
        do_reset();
        chk("rst_sample", smp(), 0);
        chk("rst_valid", int'(audio.sample_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("silence_valid", int'(audio.sample_valid), 1);
            chk("silence_sample", smp(), 0);
        end
        chk("silence_overrun", int'(overrun), 0);

        // 220 Hz square: inc 77000, sign flip at k=110, wrap at k=218
        frequency = 14'd220;
        tick();
        chk("sq_idle_tick", smp(), 0);
        tick();
        chk("sq_k1", smp(), 8192);
        run(107);
        tick();
        chk("sq_k109", smp(), 8192);
        tick();
        chk("sq_k110", smp(), -8192);
        run(107);
        tick();
        chk("sq_k218", smp(), -8192);
        tick();
        chk("sq_k219_after_wrap", smp(), 8192);

        // Sawtooth with volume 2, then retune 220 -> 440 mid-period
        do_reset();
        frequency = 14'd220;
        wave_sel  = 2'd1;
        volume    = 3'd2;
        tick();
        tick();
        chk("saw_v2_k1", smp(), -8192);
        tick();
        chk("saw_v2_k2", smp(), -8117);
        tick();
        chk("saw_v2_k3", smp(), -8042);
        volume    = 3'd0;
        frequency = 14'd440;
        tick();
        chk("retune_k4", smp(), -31866);
        tick();
        chk("pending_k5", smp(), -31565);
        tick();
        chk("pending_k6_old_inc", smp(), -31265);
        run(210);
        tick();
        chk("pending_k217", smp(), 32200);
        tick();
        chk("pending_wrap_k218", smp(), 32501);
        tick();
        chk("retuned_phase0", smp(), -32768);
        tick();
        chk("retuned_inc154000", smp(), -32167);
        tick();
        chk("retuned_k3", smp(), -31565);

        // Backpressure, overrun, simultaneous tick and consume
        do_reset();
        frequency = 14'd220;
        wave_sel  = 2'd1;
        tick();
        tick();
        chk("bp_k1", smp(), -32768);
        idle(1);
        chk("bp_drained", int'(audio.sample_valid), 0);
        audio.sample_ready = 1'b0;
        tick();
        chk("bp_k2", smp(), -32468);
        idle(1);
        chk("bp_hold_valid", int'(audio.sample_valid), 1);
        chk("bp_no_overrun_yet", int'(overrun), 0);
        tick();
        chk("bp_overrun_set", int'(overrun), 1);
        chk("bp_sample_held", smp(), -32468);
        audio.sample_ready = 1'b1;
        tick();
        chk("bp_tick_consume_sample", smp(), -32167);
        chk("bp_tick_consume_valid", int'(audio.sample_valid), 1);
        idle(1);
        chk("bp_valid_clears", int'(audio.sample_valid), 0);
        chk("bp_overrun_sticky", int'(overrun), 1);
        audio.sample_ready = 1'b0;
        tick();
        chk("bp_pending_before_rst", int'(audio.sample_valid), 1);
        do_reset();
        chk("midhs_rst_valid", int'(audio.sample_valid), 0);
        chk("midhs_rst_overrun", int'(overrun), 0);
        audio.sample_ready = 1'b1;

        // Go silent mid-period; wave_sel=2 builds as square unless triangle enabled
        frequency = 14'd220;
        wave_sel  = 2'd2;
        tick();
        run(3);
        frequency = 14'd0;
        tick();
`ifdef TONE_OSC_TRIANGLE_EN
        chk("ws2_k4", smp(), -30964);
`else
        chk("ws2_k4", smp(), 8192);
`endif
        run(213);
        tick();
`ifdef TONE_OSC_TRIANGLE_EN
        chk("ws2_wrap_k218", smp(), -32235);
`else
        chk("ws2_wrap_k218", smp(), -8192);
`endif
        tick();
        chk("silent_after_wrap", smp(), 0);
        chk("silent_valid", int'(audio.sample_valid), 1);
        tick();
        chk("silent_again", smp(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
